// File: rtl/bus_alu_seq.sv
// rtl/bus_alu_seq.sv - registered bus ALU with iterative shift and multiply
//
// Two operand registers (A, B) load from the shared bus. A start strobe
// launches an operation on them. Logic and add/sub ops finish in one clock.
// Shifts take one clock per bit position. Multiply is shift-add, one
// multiplier bit per clock.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   bus_in          shared data bus input
//   latch_a_en      load bus_in into A (ignored while busy)
//   latch_b_en      load bus_in into B (ignored while busy)
//   op, start       opcode and 1-cycle launch strobe
//   busy            operation in progress (ITER and DONE states)
//   done            1-cycle pulse when result/flags/illegal update
//   illegal         undefined opcode, updated with done
//   flags           {negative, zero, carry, overflow}, updated with done
//   result_oe       drive result register onto bus_out
//   bus_out         result register when result_oe=1, else high impedance

module bus_alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             latch_a_en,
    input  logic             latch_b_en,
    input  logic [3:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [3:0]       flags,
    input  logic             result_oe,
    output logic [WIDTH-1:0] bus_out
);

    localparam int CW = SHW + 1;
    localparam logic [CW-1:0] MUL_STEPS = CW'(WIDTH - 1);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    logic             illegal_q;
    logic             done_q;
    logic             busy_q;
    logic [3:0]       op_q;
    logic [CW-1:0]    cnt;
    // work_q holds the shifting operand for SHL/SHR and the shifted
    // multiplicand for MUL.
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mplier_q;
    logic             shc_q;

    // One-bit logical shift; MSB of the return value is the bit shifted out.
    function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic right);
        if (right)
            return {v[0], 1'b0, v[WIDTH-1:1]};
        else
            return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c,
                                            input logic v);
        return {r[WIDTH-1], (r == '0), c, v};
    endfunction

    // Single-cycle ALU on the current (pre-edge) operand registers.
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_ill;

    always_comb begin
        sum_ext = {1'b0, a_q} + {1'b0, b_q};
        diff    = a_q - b_q;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_NOP: alu_res = '0;
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_c   = (a_q < b_q);
                alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                          (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_NOT:  alu_res = ~a_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_XNOR: alu_res = ~(a_q ^ b_q);
            OP_SHL, OP_SHR, OP_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // The launch edge already performs the first shift / first multiplier
    // bit, so an op needing k steps signals done k clocks after start.
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sh_first;
    logic [WIDTH:0]   sh_iter;
    logic [WIDTH-1:0] mul_next;

    always_comb begin
        shamt    = b_q[SHW-1:0];
        sh_first = shift1(a_q, op == OP_SHR);
        sh_iter  = shift1(work_q, op_q == OP_SHR);
        mul_next = acc_q + (mplier_q[0] ? work_q : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            op_q      <= '0;
            cnt       <= '0;
            work_q    <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            shc_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (!busy_q) begin
                if (latch_a_en) a_q <= bus_in;
                if (latch_b_en) b_q <= bus_in;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q   <= op;
                        busy_q <= 1'b1;
                        if (op == OP_SHL || op == OP_SHR) begin
                            if (shamt == '0) begin
                                result_q  <= a_q;
                                flags_q   <= mk_flags(a_q, 1'b0, 1'b0);
                                illegal_q <= 1'b0;
                                done_q    <= 1'b1;
                                state     <= S_DONE;
                            end else if (shamt == SHW'(1)) begin
                                result_q  <= sh_first[WIDTH-1:0];
                                flags_q   <= mk_flags(sh_first[WIDTH-1:0],
                                                      sh_first[WIDTH], 1'b0);
                                illegal_q <= 1'b0;
                                done_q    <= 1'b1;
                                state     <= S_DONE;
                            end else begin
                                work_q <= sh_first[WIDTH-1:0];
                                shc_q  <= sh_first[WIDTH];
                                cnt    <= CW'(shamt) - CW'(1);
                                state  <= S_ITER;
                            end
                        end else if (op == OP_MUL) begin
                            acc_q    <= b_q[0] ? a_q : '0;
                            work_q   <= {a_q[WIDTH-2:0], 1'b0};
                            mplier_q <= {1'b0, b_q[WIDTH-1:1]};
                            cnt      <= MUL_STEPS;
                            state    <= S_ITER;
                        end else begin
                            result_q  <= alu_res;
                            flags_q   <= mk_flags(alu_res, alu_c, alu_v);
                            illegal_q <= alu_ill;
                            done_q    <= 1'b1;
                            state     <= S_DONE;
                        end
                    end
                end

                S_ITER: begin
                    cnt <= cnt - CW'(1);
                    if (op_q == OP_MUL) begin
                        acc_q    <= mul_next;
                        work_q   <= {work_q[WIDTH-2:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                    end else begin
                        work_q <= sh_iter[WIDTH-1:0];
                        shc_q  <= sh_iter[WIDTH];
                    end
                    if (cnt == CW'(1)) begin
                        if (op_q == OP_MUL) begin
                            result_q <= mul_next;
                            flags_q  <= mk_flags(mul_next, 1'b0, 1'b0);
                        end else begin
                            result_q <= sh_iter[WIDTH-1:0];
                            flags_q  <= mk_flags(sh_iter[WIDTH-1:0],
                                                 sh_iter[WIDTH], 1'b0);
                        end
                        illegal_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end

                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign flags   = flags_q;
    assign bus_out = result_oe ? result_q : 'z;

endmodule
